// File: rtl/door_game_ctrl.sv
// Game-round controller for the door game: round timer, LFSR door pick, lives and winner.
// Optional feature: define DOOR_GAME_SPEEDUP_EN to shorten each round by one tick down to MIN_SECS.
//
//  state     | meaning
//  ----------+--------------------------------------------------
//  IDLE      | waiting for the first start pulse
//  ROUND     | timer running, collecting one choice per player
//  REVEAL    | time_up shown; lives already charged
//  GAME_OVER | winner shown; start begins a new game
module door_game_ctrl #(
    parameter int          N_PLAYERS   = 2,
    parameter int          N_DOORS     = 4,
    parameter int          LIVES_INIT  = 3,
    parameter int          TICK_DIV    = 25000000,
    parameter int          ROUND_SECS  = 10,
    parameter int          REVEAL_SECS = 2,
    parameter int          MIN_SECS    = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         DW          = $clog2(N_DOORS),
    localparam int         LW          = $clog2(LIVES_INIT + 1),
    localparam int         SW          = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [N_PLAYERS-1:0]    choice_valid,
    input  logic [N_PLAYERS*DW-1:0] choice_door,
    output logic [DW-1:0]           correct_door,
    output logic [N_PLAYERS*LW-1:0] lives,
    output logic [SW-1:0]           seconds_left,
    output logic                    time_up,
    output logic                    round_active,
    output logic                    game_over,
    output logic [N_PLAYERS-1:0]    winner,
    output logic [7:0]              round_num
);

    localparam int PW        = $clog2(TICK_DIV + 1);
    localparam int ALIVE_MAX = (N_PLAYERS > 1) ? 1 : 0;

    typedef enum logic [1:0] {IDLE, ROUND, REVEAL, GAME_OVER} state_t;

    state_t                  state, state_nxt;
    logic [15:0]             lfsr;
    logic [PW-1:0]           prescaler;
    logic [5:0]              reveal_cnt;
    logic [N_PLAYERS-1:0]    lock;
    logic [N_PLAYERS*DW-1:0] pick;
    logic [N_PLAYERS-1:0]    alive;
    logic [2:0]              alive_cnt;
    logic                    tick, expire, all_locked, last_reveal;
    logic                    enter_round, enter_reveal, enter_over, restart;
    logic [SW-1:0]           round_len;

    assign tick        = (prescaler == PW'(TICK_DIV - 1));
    assign expire      = (state == ROUND) && tick && (seconds_left == SW'(1));
    assign all_locked  = &(lock | ~alive);
    assign last_reveal = tick && (reveal_cnt == 6'd1);

    always_comb begin
        alive     = '0;
        alive_cnt = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            alive[p]  = (lives[p*LW +: LW] != '0);
            alive_cnt = alive_cnt + 3'(alive[p]);
        end
    end

`ifdef DOOR_GAME_SPEEDUP_EN
    logic [9:0] rn_ext;
    // rn_ext is the number of rounds already played, i.e. the new round_num minus one
    assign rn_ext    = restart ? 10'd0 : {2'b00, round_num};
    assign round_len = (rn_ext + 10'(MIN_SECS) >= 10'(ROUND_SECS)) ? SW'(MIN_SECS)
                                                                   : SW'(10'(ROUND_SECS) - rn_ext);
`else
    assign round_len = SW'(ROUND_SECS);
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        enter_round  = 1'b0;
        enter_reveal = 1'b0;
        enter_over   = 1'b0;
        restart      = 1'b0;
        case (state)
            IDLE: if (start) begin
                enter_round = 1'b1;
                state_nxt   = ROUND;
            end
            ROUND: if (expire || all_locked) begin
                enter_reveal = 1'b1;
                state_nxt    = REVEAL;
            end
            REVEAL: if (last_reveal) begin
                if (alive_cnt <= 3'(ALIVE_MAX)) begin
                    enter_over = 1'b1;
                    state_nxt  = GAME_OVER;
                end else begin
                    enter_round = 1'b1;
                    state_nxt   = ROUND;
                end
            end
            GAME_OVER: if (start) begin
                restart     = 1'b1;
                enter_round = 1'b1;
                state_nxt   = ROUND;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr         <= LFSR_SEED;
            prescaler    <= '0;
            reveal_cnt   <= '0;
            lock         <= '0;
            pick         <= '0;
            correct_door <= '0;
            lives        <= {N_PLAYERS{LW'(LIVES_INIT)}};
            seconds_left <= SW'(ROUND_SECS);
            time_up      <= 1'b0;
            round_active <= 1'b0;
            game_over    <= 1'b0;
            winner       <= '0;
            round_num    <= 8'd0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

            if (state == ROUND || state == REVEAL)
                prescaler <= tick ? '0 : prescaler + PW'(1);

            if (state == ROUND && tick)
                seconds_left <= seconds_left - SW'(1);

            if (state == REVEAL && tick)
                reveal_cnt <= reveal_cnt - 6'd1;

            // A pulse arriving on the expiring tick is too late to count.
            if (state == ROUND && !expire) begin
                for (int p = 0; p < N_PLAYERS; p++) begin
                    if (choice_valid[p] && alive[p] && !lock[p]) begin
                        lock[p]            <= 1'b1;
                        pick[p*DW +: DW]   <= choice_door[p*DW +: DW];
                    end
                end
            end

            if (enter_reveal) begin
                prescaler    <= '0;
                reveal_cnt   <= 6'(REVEAL_SECS);
                time_up      <= 1'b1;
                round_active <= 1'b0;
                for (int p = 0; p < N_PLAYERS; p++) begin
                    if (alive[p] && (!lock[p] || pick[p*DW +: DW] != correct_door))
                        lives[p*LW +: LW] <= lives[p*LW +: LW] - LW'(1);
                end
            end

            if (enter_over) begin
                time_up   <= 1'b0;
                game_over <= 1'b1;
                winner    <= alive;
            end

            if (enter_round) begin
                prescaler    <= '0;
                lock         <= '0;
                correct_door <= lfsr[DW-1:0];
                seconds_left <= round_len;
                time_up      <= 1'b0;
                round_active <= 1'b1;
                game_over    <= 1'b0;
                winner       <= '0;
                if (restart) begin
                    lives     <= {N_PLAYERS{LW'(LIVES_INIT)}};
                    round_num <= 8'd1;
                end else if (round_num != 8'hFF) begin
                    round_num <= round_num + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_door_game_ctrl.sv
// Bench for door_game_ctrl: directed game scenarios followed by random play, checked every cycle
// against a timeline model built from elapsed cycle counts.
module tb_door_game_ctrl;

`ifdef DOOR_GAME_SPEEDUP_EN
    localparam bit SPEED = 1'b1;
    localparam int RS    = 5;
`else
    localparam bit SPEED = 1'b0;
    localparam int RS    = 3;
`endif
    localparam int NP = 2, ND = 4, LI = 3, TD = 4, RV = 1, MINS = 3;
    localparam int DW = 2, LW = 2, SW = 6;
    localparam int LEN2 = SPEED ? RS - 1 : RS;

    localparam int PH_IDLE = 0, PH_ROUND = 1, PH_REVEAL = 2, PH_OVER = 3;

    logic              clk = 1'b0;
    logic              reset, start;
    logic [NP-1:0]     choice_valid;
    logic [NP*DW-1:0]  choice_door;
    logic [DW-1:0]     correct_door;
    logic [NP*LW-1:0]  lives;
    logic [SW-1:0]     seconds_left;
    logic              time_up, round_active, game_over;
    logic [NP-1:0]     winner;
    logic [7:0]        round_num;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    door_game_ctrl #(
        .N_PLAYERS(NP), .N_DOORS(ND), .LIVES_INIT(LI), .TICK_DIV(TD),
        .ROUND_SECS(RS), .REVEAL_SECS(RV), .MIN_SECS(MINS), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .choice_valid(choice_valid), .choice_door(choice_door),
        .correct_door(correct_door), .lives(lives), .seconds_left(seconds_left),
        .time_up(time_up), .round_active(round_active), .game_over(game_over),
        .winner(winner), .round_num(round_num)
    );

    always #5 clk = ~clk;

    // Model: the round timer is just "cycles elapsed since the round began".
    int          m_phase, m_door, m_rn, m_cyc, m_len, m_secs;
    int          m_lives [NP];
    int          m_pick  [NP];
    logic [15:0] m_lfsr;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic enter_round(input logic [15:0] cur);
        m_door  = int'(cur[DW-1:0]);
        m_rn    = (m_rn < 255) ? m_rn + 1 : 255;
        m_len   = SPEED ? ((RS - (m_rn - 1) > MINS) ? RS - (m_rn - 1) : MINS) : RS;
        m_secs  = m_len;
        m_cyc   = 0;
        m_phase = PH_ROUND;
        for (int p = 0; p < NP; p++) m_pick[p] = -1;
    endtask

    task automatic model_step();
        logic [15:0] cur;
        int          alive_n;
        bit          all_lk, expired;
        if (reset) begin
            m_phase = PH_IDLE; m_door = 0; m_rn = 0; m_cyc = 0; m_len = RS; m_secs = RS;
            m_lfsr  = 16'hACE1;
            for (int p = 0; p < NP; p++) begin m_lives[p] = LI; m_pick[p] = -1; end
            return;
        end
        cur    = m_lfsr;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        case (m_phase)
            PH_IDLE: if (start) enter_round(cur);
            PH_ROUND: begin
                m_cyc++;
                m_secs  = m_len - m_cyc / TD;
                expired = (m_cyc == m_len * TD);
                all_lk  = 1'b1;
                for (int p = 0; p < NP; p++)
                    if (m_lives[p] > 0 && m_pick[p] < 0) all_lk = 1'b0;
                if (expired || all_lk) begin
                    for (int p = 0; p < NP; p++)
                        if (m_lives[p] > 0 && m_pick[p] != m_door) m_lives[p]--;
                    m_phase = PH_REVEAL;
                    m_cyc   = 0;
                end else begin
                    for (int p = 0; p < NP; p++)
                        if (choice_valid[p] && m_lives[p] > 0 && m_pick[p] < 0)
                            m_pick[p] = int'(choice_door[p*DW +: DW]);
                end
            end
            PH_REVEAL: begin
                m_cyc++;
                if (m_cyc == RV * TD) begin
                    alive_n = 0;
                    for (int p = 0; p < NP; p++) if (m_lives[p] > 0) alive_n++;
                    if (alive_n <= ((NP > 1) ? 1 : 0)) m_phase = PH_OVER;
                    else                               enter_round(cur);
                end
            end
            default: if (start) begin
                for (int p = 0; p < NP; p++) m_lives[p] = LI;
                m_rn = 0;
                enter_round(cur);
            end
        endcase
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (cmp_en) begin
            int exp_l, exp_w;
            exp_l = 0;
            exp_w = 0;
            for (int p = 0; p < NP; p++) begin
                exp_l |= m_lives[p] << (p * LW);
                if (m_phase == PH_OVER && m_lives[p] > 0) exp_w |= 1 << p;
            end
            check("correct_door", int'(correct_door), m_door);
            check("lives",        int'(lives),        exp_l);
            check("seconds_left", int'(seconds_left), m_secs);
            check("time_up",      int'(time_up),      int'(m_phase == PH_REVEAL));
            check("round_active", int'(round_active), int'(m_phase == PH_ROUND));
            check("game_over",    int'(game_over),    int'(m_phase == PH_OVER));
            check("winner",       int'(winner),       exp_w);
            check("round_num",    int'(round_num),    m_rn);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic choose(input logic [NP-1:0] mask, input int d0, input int d1);
        choice_valid = mask;
        choice_door  = {DW'(d1), DW'(d0)};
        @(negedge clk);
        choice_valid = '0;
    endtask

    initial begin
        int d;
        reset = 1'b1; start = 1'b0; choice_valid = '0; choice_door = '0;
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_round_num", int'(round_num), 0);
        check("rst_lives", int'(lives), 4'b1111);
        reset = 1'b0;
        @(negedge clk);

        // first round, nobody chooses
        pulse_start();
        check("start_round_active", int'(round_active), 1);
        check("start_round_num", int'(round_num), 1);
        check("start_seconds", int'(seconds_left), RS);
        repeat (RS * TD) @(negedge clk);
        check("timeout_time_up", int'(time_up), 1);
        check("timeout_lives", int'(lives), 4'b1010);
        repeat (RV * TD) @(negedge clk);
        check("round2_active", int'(round_active), 1);
        check("round2_seconds", int'(seconds_left), LEN2);

        // P0 right, P1 wrong: early reveal the cycle after both lock
        d = m_door;
        choose(2'b11, d, (d + 1) % ND);
        @(negedge clk);
        check("early_time_up", int'(time_up), 1);
        check("early_lives", int'(lives), 4'b0110);

        repeat (RV * TD) @(negedge clk);
        d = m_door;
        choose(2'b11, d, (d + 1) % ND);
        @(negedge clk);
        check("last_life_lives", int'(lives), 4'b0010);
        repeat (RV * TD) @(negedge clk);
        check("over_game_over", int'(game_over), 1);
        check("over_winner", int'(winner), 2'b01);
        pulse_start();
        check("restart_lives", int'(lives), 4'b1111);
        check("restart_round_num", int'(round_num), 1);

        // repeated pulse from P0 and a late pulse on the expiring tick
        d = m_door;
        choose(2'b01, d, 0);
        choose(2'b01, (d + 1) % ND, 0);
        repeat (RS * TD - 3) @(negedge clk);
        choose(2'b10, 0, d);
        check("ignored_time_up", int'(time_up), 1);
        check("ignored_lives", int'(lives), 4'b1011);

        repeat (RV * TD + 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_round_active", int'(round_active), 0);
        check("midreset_round_num", int'(round_num), 0);
        check("midreset_lives", int'(lives), 4'b1111);
        check("midreset_seconds", int'(seconds_left), RS);
        check("midreset_door", int'(correct_door), 0);

        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 799) == 0);
            start = ($urandom_range(0, 9) == 0);
            for (int p = 0; p < NP; p++) begin
                choice_valid[p] = ($urandom_range(0, 5) == 0);
                choice_door[p*DW +: DW] = $urandom_range(0, 1) ? DW'(m_door) : DW'($urandom);
            end
            @(negedge clk);
        end
        reset = 1'b0; start = 1'b0; choice_valid = '0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
